ray_sphere_intersector: RTL and testbench

Per-pixel ray/sphere intersection stage sitting directly upstream of `color_determinator`: it accepts a screen pixel coordinate, casts an orthographic ray along +z, and produces the `intersection_location` / `is_intersecting` pair that `color_determinator` consumes. The depth term needs a square root, computed by an iterative bit-serial unit. A valid/ready handshake on both sides decouples the block from pixel timing and from the shading stage.

---
 rtl/ray_sphere_intersector.sv | 189 ++++++++++++++++++
 tb/tb_ray_sphere_intersector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ray_sphere_intersector.sv
// ray_sphere_intersector
//   Casts an orthographic ray along +z from screen pixel (x,y) against one
//   sphere. It produces the front hit point {z,y,x} and a hit flag for
//   color_determinator.
//   The depth term sqrt(R^2 - dx^2 - dy^2) comes from a restoring bit-serial
//   square root. The root takes 12 cycles and yields one result bit per cycle.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        pixel request handshake (pixel_x, pixel_y)
//   out_valid/out_ready      result handshake
//   intersection_location    [0]=x, [1]=y, [2]=z of hit point (0 on miss)
//   is_intersecting          ray hits the sphere
//
// Optional feature macro: RAY_SPHERE_RUNTIME_SPHERE_EN
//   When this macro is defined, the ports sphere_cx/cy/cz/r are added.
//   They are sampled on each accept and override the SPHERE_* parameters
//   for that request.
module ray_sphere_intersector #(
  parameter logic [11:0] SPHERE_CX = 12'd320,
  parameter logic [11:0] SPHERE_CY = 12'd240,
  parameter logic [11:0] SPHERE_CZ = 12'd1024,
  parameter logic [11:0] SPHERE_R  = 12'd100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      pixel_x,
  input  logic [11:0]      pixel_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0][11:0] intersection_location,
  output logic             is_intersecting
`ifdef RAY_SPHERE_RUNTIME_SPHERE_EN
  ,
  input  logic [11:0]      sphere_cx,
  input  logic [11:0]      sphere_cy,
  input  logic [11:0]      sphere_cz,
  input  logic [11:0]      sphere_r
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SQUARE = 2'd1;
  localparam logic [1:0] ROOT   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]  state;
  logic [11:0] x_q, y_q;
  logic [23:0] rad_q;   // radicand, consumed two bits per step from the top
  logic [13:0] rem_q;   // partial remainder, always <= 2*root < 2^13
  logic [11:0] root_q;
  logic [3:0]  cnt_q;

  // Active sphere geometry
  logic [11:0] cx, cy, cz, r;

`ifdef RAY_SPHERE_RUNTIME_SPHERE_EN
  logic [11:0] cx_q, cy_q, cz_q, r_q;

  // The parameters serve as the power-up sphere. Every request overwrites
  // these registers at accept time, so a request never sees the reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q <= SPHERE_CX;
      cy_q <= SPHERE_CY;
      cz_q <= SPHERE_CZ;
      r_q  <= SPHERE_R;
    end else if (state == IDLE && in_valid) begin
      cx_q <= sphere_cx;
      cy_q <= sphere_cy;
      cz_q <= sphere_cz;
      r_q  <= sphere_r;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;
  assign cz = cz_q;
  assign r  = r_q;
`else
  assign cx = SPHERE_CX;
  assign cy = SPHERE_CY;
  assign cz = SPHERE_CZ;
  assign r  = SPHERE_R;
`endif

  assign in_ready = (state == IDLE) && !rst;

  // ------------------------------------------------------------------
  // SQUARE stage: d = R^2 - dx^2 - dy^2 at full precision.
  // |dx|,|dy| <= 4095, so every square fits in 24 bits unsigned.
  // The worst case d = -2*4095^2 still fits in signed 26 bits.
  // ------------------------------------------------------------------
  logic signed [12:0] dx, dy;
  logic        [23:0] dx_sq, dy_sq, r_sq;
  logic signed [25:0] d;

  always_comb begin
    dx    = $signed({1'b0, x_q}) - $signed({1'b0, cx});
    dy    = $signed({1'b0, y_q}) - $signed({1'b0, cy});
    dx_sq = 24'(dx * dx);
    dy_sq = 24'(dy * dy);
    r_sq  = {12'd0, r} * {12'd0, r};
    d     = $signed({2'b00, r_sq}) - $signed({2'b00, dx_sq}) - $signed({2'b00, dy_sq});
  end

  // ------------------------------------------------------------------
  // One restoring square-root step. The next radicand bit pair is appended
  // to the remainder, and the trial value 4*root+1 is subtracted if it fits.
  // ------------------------------------------------------------------
  logic [15:0] rem_sh, trial;
  logic        take;
  logic [11:0] root_nx;
  logic [11:0] z_nx;

  always_comb begin
    rem_sh  = {rem_q, rad_q[23:22]};
    trial   = {2'b00, root_q, 2'b01};
    take    = (rem_sh >= trial);
    root_nx = {root_q[10:0], take};
    // Points with a depth larger than the sphere centre would lie behind
    // z=0, so they are clamped to the screen plane.
    z_nx    = (root_nx > cz) ? 12'd0 : (cz - root_nx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      x_q                   <= '0;
      y_q                   <= '0;
      rad_q                 <= '0;
      rem_q                 <= '0;
      root_q                <= '0;
      cnt_q                 <= '0;
      out_valid             <= 1'b0;
      is_intersecting       <= 1'b0;
      intersection_location <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= pixel_x;
            y_q   <= pixel_y;
            state <= SQUARE;
          end
        end
        SQUARE: begin
          if (d < 0) begin
            is_intersecting       <= 1'b0;
            intersection_location <= '0;
            out_valid             <= 1'b1;
            state                 <= HOLD;
          end else begin
            // Because d <= R^2 < 2^24, the low 24 bits hold the whole value.
            rad_q  <= d[23:0];
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= 4'd11;
            state  <= ROOT;
          end
        end
        ROOT: begin
          rem_q  <= take ? 14'(rem_sh - trial) : rem_sh[13:0];
          root_q <= root_nx;
          rad_q  <= {rad_q[21:0], 2'b00};
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            intersection_location[0] <= x_q;
            intersection_location[1] <= y_q;
            intersection_location[2] <= z_nx;
            is_intersecting          <= 1'b1;
            out_valid                <= 1'b1;
            state                    <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_sphere_intersector.sv
// Randomized plus directed checks of ray_sphere_intersector against a
// plain-arithmetic reference model (integer sqrt by search).
module tb_ray_sphere_intersector;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      pixel_x, pixel_y;
  logic             out_valid;
  logic             out_ready;
  logic [2:0][11:0] intersection_location;
  logic             is_intersecting;

  int scx = 320, scy = 240, scz = 1024, sr = 100;

`ifdef RAY_SPHERE_RUNTIME_SPHERE_EN
  logic [11:0] sphere_cx, sphere_cy, sphere_cz, sphere_r;
  always_comb begin
    sphere_cx = scx[11:0];
    sphere_cy = scy[11:0];
    sphere_cz = scz[11:0];
    sphere_r  = sr[11:0];
  end
`endif

  ray_sphere_intersector dut (
    .clk                   (clk),
    .rst                   (rst),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .pixel_x               (pixel_x),
    .pixel_y               (pixel_y),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .intersection_location (intersection_location),
    .is_intersecting       (is_intersecting)
`ifdef RAY_SPHERE_RUNTIME_SPHERE_EN
    ,
    .sphere_cx             (sphere_cx),
    .sphere_cy             (sphere_cy),
    .sphere_cz             (sphere_cz),
    .sphere_r              (sphere_r)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: hit iff R^2 >= dx^2 + dy^2, depth = floor(sqrt(d)), and z = cz - depth clamped at 0.
  function automatic void model(input int x, input int y, output bit hit, output logic [35:0] loc);
    longint dd;
    int root;
    int z;
    dd = longint'(sr) * sr - longint'(x - scx) * (x - scx) - longint'(y - scy) * (y - scy);
    if (dd < 0) begin
      hit = 1'b0;
      loc = '0;
    end else begin
      root = 0;
      while (longint'(root + 1) * (root + 1) <= dd) root++;
      z   = (root > scz) ? 0 : scz - root;
      hit = 1'b1;
      loc = {z[11:0], y[11:0], x[11:0]};
    end
  endfunction

  // Issues one request, checks latency and result, and holds out_ready low
  // for 'stall' cycles while random in_valid pulses occur. Then it completes the handshake.
  task automatic run_req(input int x, input int y, input int stall);
    bit          hit;
    logic [35:0] eloc;
    int          lat;
    model(x, y, hit, eloc);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    pixel_x   = x[11:0];
    pixel_y   = y[11:0];
    out_ready = 1'b0;
    @(posedge clk);            // accept edge T
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, hit ? 14 : 2);
    chk("hit", is_intersecting, hit);
    chk("loc", intersection_location, eloc);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      pixel_x  = 12'($urandom);
      pixel_y  = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_hit", is_intersecting, hit);
      chk("stall_loc", intersection_location, eloc);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);            // handshake edge H
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_cleared", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pixel_x   = '0;
    pixel_y   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hit", is_intersecting, 0);
    chk("rst_loc", intersection_location, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_post_rst", in_ready, 1);

    // Directed cases: centre, interior, tangent, miss
    run_req(320, 240, 0);
    run_req(330, 240, 0);
    run_req(420, 240, 0);
    run_req(0, 0, 0);
    run_req(320, 240, 5);      // held result with ignored in_valid pulses
    run_req(0, 0, 3);

    // The request is abandoned by a reset that occurs mid-ROOT
    @(negedge clk);
    in_valid = 1'b1;
    pixel_x  = 12'd320;
    pixel_y  = 12'd240;
    @(posedge clk);            // T
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;                // sampled at T+6
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_hit", is_intersecting, 0);
    chk("midrst_loc", intersection_location, 0);
    chk("midrst_in_ready_after", in_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_pulse", seen, 0);

    // Randomized pixels near the sphere, then across the full range
    for (int i = 0; i < 30; i++)
      run_req($urandom_range(200, 440), $urandom_range(130, 350), $urandom_range(0, 3));
    for (int i = 0; i < 6; i++)
      run_req($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 2));

`ifdef RAY_SPHERE_RUNTIME_SPHERE_EN
    // Depth exceeds the centre z: clamp to the screen plane
    scz = 50;
    run_req(320, 240, 0);
    for (int i = 0; i < 8; i++) begin
      scx = $urandom_range(100, 3000);
      scy = $urandom_range(100, 3000);
      scz = $urandom_range(0, 4095);
      sr  = $urandom_range(0, 400);
      run_req(scx + $urandom_range(0, 300) - 150, scy + $urandom_range(0, 300) - 150, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
